spi_master_gen: RTL and testbench

Parametrised SPI master, next generation of the processor's serial interface. Adds all four SPI modes (CPOL/CPHA), a programmable SCLK divider instead of SCLK=clk, per-transfer frame length, and NUM_CS one-hot-decoded chip selects. Full-duplex and MSB-first: shifts out tx_data_in while capturing miso_in. Sits between the core's I/O unit and external SPI devices (memory/driver peripherals).

---
 rtl/spi_master_gen_pkg.sv | 20 ++
 rtl/spi_master_gen_clk.sv | 48 ++++
 rtl/spi_master_gen.sv | 156 +++++++++++++++
 tb/tb_spi_master_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spi_master_gen_pkg.sv
// rtl/spi_master_gen_pkg.sv - shared state encoding and sizing helpers for the SPI master
package spi_master_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Processor datapath width and data-memory depth set the default frame shape
    localparam int DATAPATH_W = 8;
    localparam int DMEM_SZ    = 16;

    // ceil(log2(n)) but never zero, so single-entry selects still get a 1-bit port
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_gen_clk.sv
// rtl/spi_master_gen_clk.sv - SCLK divider, half-period tick and edge strobes
module spi_master_gen_clk
    import spi_master_gen_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic             load_level,
    input  logic             cpol,
    input  logic             toggle,
    output logic             tick,
    output logic             lead,
    output logic             trail,
    output logic             sclk
);

    logic [DIV_W-1:0] cnt;

    // Half-period counter; wraps at div so every phase restarts at zero
    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (cnt == div)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick  = en && (cnt == div);
    // A toggle away from the idle level is a leading edge, back to it a trailing edge
    assign lead  = toggle && (sclk == cpol);
    assign trail = toggle && (sclk != cpol);

    // SCLK level: idle level loaded when a transfer is accepted, flipped on toggles
    always_ff @(posedge clk) begin
        if (rst)
            sclk <= 1'b0;
        else if (load)
            sclk <= load_level;
        else if (toggle)
            sclk <= ~sclk;
    end

endmodule

// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - four-mode SPI master with divider, variable frame length and CS decode
module spi_master_gen
    import spi_master_gen_pkg::*;
#(
    parameter int  DATA_W  = DATAPATH_W,
    parameter int  ADDR_W  = $clog2(DMEM_SZ),
    parameter int  NUM_CS  = 2,
    parameter int  DIV_W   = 8,
    localparam int FRAME_W = DATA_W + ADDR_W,
    localparam int LEN_W   = $clog2(FRAME_W + 1),
    localparam int CS_W    = clog2_min1(NUM_CS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_in,
    input  logic [CS_W-1:0]    cs_sel_in,
    input  logic               cpol_in,
    input  logic               cpha_in,
    input  logic [DIV_W-1:0]   div_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic [FRAME_W-1:0] tx_data_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [FRAME_W-1:0] rx_data_out,
    output logic               sclk_out,
    output logic               mosi_out,
    input  logic               miso_in,
    output logic [NUM_CS-1:0]  cs_n_out
);

    localparam int CNT_W = LEN_W + 1;

    state_t             state, state_next;
    logic               tick, lead, trail, toggle, finish, accept, sample;
    logic               cpol_l, cpha_l;
    logic [DIV_W-1:0]   div_l;
    logic [LEN_W-1:0]   len_l, len_eff;
    logic [CNT_W-1:0]   edge_cnt, two_l;
    logic [FRAME_W-1:0] tx_sh, rx_sh, tx_aligned;
    logic [NUM_CS-1:0]  cs_dec;

    assign accept   = (state == ST_IDLE) && start_in;
    assign busy_out = (state != ST_IDLE);
    assign two_l    = {len_l, 1'b0};

    spi_master_gen_clk #(.DIV_W(DIV_W)) u_clk (
        .clk        (clk),
        .rst        (rst),
        .en         (busy_out),
        .div        (div_l),
        .load       (accept),
        .load_level (cpol_in),
        .cpol       (cpol_l),
        .toggle     (toggle),
        .tick       (tick),
        .lead       (lead),
        .trail      (trail),
        .sclk       (sclk_out)
    );

    // Effective length (0 or oversize means full frame), MSB-align the frame, decode CS
    always_comb begin
        len_eff = len_in;
        if (len_in == '0 || int'(len_in) > FRAME_W)
            len_eff = LEN_W'(FRAME_W);
        tx_aligned = tx_data_in << (FRAME_W - int'(len_eff));
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(cs_sel_in) == i)
                cs_dec[i] = 1'b0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next state plus the SCLK toggle request and end-of-transfer strobe
    always_comb begin
        state_next = state;
        toggle     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE:  if (start_in) state_next = ST_SETUP;
            ST_SETUP: if (tick) begin
                state_next = ST_XFER;
                toggle     = 1'b1;
            end
            ST_XFER:  if (tick) begin
                if (edge_cnt == two_l)
                    state_next = ST_HOLD;
                else
                    toggle = 1'b1;
            end
            ST_HOLD:  if (tick) begin
                state_next = ST_IDLE;
                finish     = 1'b1;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Transfer datapath: latch settings, shift MOSI on launch edges, capture MISO on sample edges
    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            div_l       <= '0;
            len_l       <= '0;
            edge_cnt    <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            sample      <= 1'b0;
            mosi_out    <= 1'b0;
            cs_n_out    <= '1;
            done_out    <= 1'b0;
            rx_data_out <= '0;
        end else begin
            done_out <= finish;
            // Capture happens in the cycle right after the sampling edge appears on SCLK
            sample   <= cpha_l ? trail : lead;
            if (accept) begin
                cpol_l   <= cpol_in;
                cpha_l   <= cpha_in;
                div_l    <= div_in;
                len_l    <= len_eff;
                edge_cnt <= '0;
                rx_sh    <= '0;
                cs_n_out <= cs_dec;
                if (!cpha_in) begin
                    mosi_out <= tx_aligned[FRAME_W-1];
                    tx_sh    <= tx_aligned << 1;
                end else begin
                    tx_sh    <= tx_aligned;
                end
            end
            if (toggle)
                edge_cnt <= edge_cnt + 1'b1;
            // CPHA=0 launches on trailing edges except the final one; CPHA=1 on leading edges
            if (cpha_l ? lead : (trail && edge_cnt != two_l - 1'b1)) begin
                mosi_out <= tx_sh[FRAME_W-1];
                tx_sh    <= tx_sh << 1;
            end
            if (sample)
                rx_sh <= {rx_sh[FRAME_W-2:0], miso_in};
            if (finish) begin
                cs_n_out    <= '1;
                rx_data_out <= rx_sh;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_gen.sv
// tb/tb_spi_master_gen.sv - randomized and directed bench with a behavioural SPI slave
module tb_spi_master_gen;

    localparam int FRAME_W = 12;
    localparam int NUM_CS  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_in;
    logic [1:0]   cs_sel_in;
    logic         cpol_in, cpha_in;
    logic [7:0]   div_in;
    logic [3:0]   len_in;
    logic [11:0]  tx_data_in;
    logic         busy_out, done_out, sclk_out, mosi_out, miso_in;
    logic [11:0]  rx_data_out;
    logic [2:0]   cs_n_out;

    int           checks = 0;
    int           failures = 0;
    logic [11:0]  last_rx = '0;

    spi_master_gen #(.NUM_CS(NUM_CS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start_in),
        .cs_sel_in   (cs_sel_in),
        .cpol_in     (cpol_in),
        .cpha_in     (cpha_in),
        .div_in      (div_in),
        .len_in      (len_in),
        .tx_data_in  (tx_data_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .rx_data_out (rx_data_out),
        .sclk_out    (sclk_out),
        .mosi_out    (mosi_out),
        .miso_in     (miso_in),
        .cs_n_out    (cs_n_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer against a mode-aware slave; poke_at>0 re-pulses start_in mid-transfer
    task automatic run_xfer(input logic pol, input logic pha, input logic [7:0] dv, input logic [3:0] ln,
                            input logic [1:0] sel, input logic [11:0] tx, input logic [11:0] sw,
                            input int poke_at);
        int l, h, exp_done, got_done, dones, edges, bad_cs, bad_mosi, bad_rx, idx;
        logic [11:0] mask, slave_rx;
        logic [2:0]  want_cs;
        logic        prev_sclk, prev_mosi, is_lead, launch;
        l        = (ln == 0 || ln > 12) ? 12 : int'(ln);
        h        = int'(dv) + 1;
        exp_done = 1 + h * (2 * l + 2);
        mask     = 12'((32'd1 << l) - 1);
        want_cs  = (sel < NUM_CS) ? ~(3'b001 << sel) : 3'b111;
        got_done = -1; dones = 0; edges = 0; bad_cs = 0; bad_mosi = 0; bad_rx = 0; idx = 0;
        slave_rx = '0; prev_sclk = 1'b0; prev_mosi = 1'b0;
        @(negedge clk);
        cpol_in = pol; cpha_in = pha; div_in = dv; len_in = ln; cs_sel_in = sel; tx_data_in = tx;
        start_in = 1'b1;
        @(posedge clk);
        #1 start_in = 1'b0;
        for (int k = 1; k <= exp_done + 4; k++) begin
            @(negedge clk);
            if (busy_out) begin
                if (cs_n_out !== want_cs) bad_cs++;
                if (rx_data_out !== last_rx) bad_rx++;
            end
            if (k == 1) begin
                chk("setup_sclk", sclk_out, pol);
                chk("setup_busy", busy_out, 1);
                if (!pha) begin
                    chk("setup_mosi", mosi_out, tx[l-1]);
                    miso_in = sw[l-1];
                    idx = 1;
                end
            end else if (busy_out) begin
                launch = 1'b0;
                if (sclk_out != prev_sclk) begin
                    edges++;
                    is_lead = (sclk_out != pol);
                    launch  = (is_lead == pha);
                    if (is_lead != pha) begin
                        slave_rx = {slave_rx[10:0], mosi_out};
                    end else if (idx < l) begin
                        miso_in = sw[l-1-idx];
                        idx++;
                    end
                end
                if (mosi_out != prev_mosi && !launch) bad_mosi++;
            end
            prev_sclk = sclk_out;
            prev_mosi = mosi_out;
            if (done_out) begin
                dones++;
                if (got_done < 0) got_done = k;
            end
            if (k == poke_at) begin
                start_in = 1'b1; tx_data_in = ~tx; len_in = ln + 4'd3;
                cpol_in = ~pol; cpha_in = ~pha; div_in = dv + 8'd1; cs_sel_in = sel + 2'd1;
            end else begin
                start_in = 1'b0;
            end
        end
        start_in = 1'b0;
        chk("done_cycle", got_done, exp_done);
        chk("done_pulses", dones, 1);
        chk("rx_data", rx_data_out, sw & mask);
        chk("mosi_bits", slave_rx & mask, tx & mask);
        chk("sclk_edges", edges, 2 * l);
        chk("cs_n_busy", bad_cs, 0);
        chk("mosi_timing", bad_mosi, 0);
        chk("rx_hold", bad_rx, 0);
        chk("idle_busy", busy_out, 0);
        chk("idle_cs", cs_n_out, 3'b111);
        chk("idle_sclk", sclk_out, pol);
        last_rx = sw & mask;
    endtask

    initial begin
        int late_done;
        rst = 1'b1; start_in = 1'b0; cs_sel_in = '0; cpol_in = 1'b0; cpha_in = 1'b0;
        div_in = '0; len_in = '0; tx_data_in = '0; miso_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_rx", rx_data_out, 0);
        chk("rst_sclk", sclk_out, 0);
        chk("rst_mosi", mosi_out, 0);
        chk("rst_cs", cs_n_out, 3'b111);

        run_xfer(1'b0, 1'b0, 8'd0, 4'd8, 2'd0, 12'h0A5, 12'h0A5, 0);
        run_xfer(1'b1, 1'b1, 8'd3, 4'd12, 2'd1, 12'($urandom), 12'h9C3, 0);
        run_xfer(1'b0, 1'b1, 8'd1, 4'd0, 2'd0, 12'($urandom), 12'($urandom), 0);
        run_xfer(1'b0, 1'b0, 8'd2, 4'd10, 2'd2, 12'($urandom), 12'($urandom), 20);
        run_xfer(1'b1, 1'b0, 8'd0, 4'd4, 2'd3, 12'($urandom), 12'($urandom), 0);
        run_xfer(1'b0, 1'b0, 8'd0, 4'd15, 2'd0, 12'($urandom), 12'($urandom), 0);
        run_xfer(1'b1, 1'b1, 8'd255, 4'd1, 2'd1, 12'($urandom), 12'($urandom), 0);

        // Reset in the middle of a mode-3 transfer
        @(negedge clk);
        cpol_in = 1'b1; cpha_in = 1'b1; div_in = 8'd1; len_in = 4'd8; cs_sel_in = 2'd0;
        tx_data_in = 12'h3C5; start_in = 1'b1;
        @(posedge clk);
        #1 start_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst_busy", busy_out, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_cs", cs_n_out, 3'b111);
        chk("midrst_sclk", sclk_out, 0);
        chk("midrst_busy", busy_out, 0);
        chk("midrst_rx", rx_data_out, 0);
        late_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_out) late_done++;
            @(negedge clk);
        end
        chk("midrst_no_done", late_done, 0);
        last_rx = '0;
        run_xfer(1'b0, 1'b0, 8'd1, 4'd8, 2'd0, 12'($urandom), 12'($urandom), 0);

        for (int n = 0; n < 8; n++) begin
            run_xfer(1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)), 4'($urandom),
                     2'($urandom), 12'($urandom), 12'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
